spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter: VERSION, 8'h01, value returned at address 0x05.
REQ-002 Parameter: SYNC_BYTE, 8'hA5, tx_byte value while the command byte is being received.
REQ-003 Port: clk  input  1  single system clock (100 MHz domain); all logic in this block is clocked by it.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: cs_n  input  1  SPI chip select, active low, already synchronized to clk upstream.
REQ-006 Port: rx_byte  input  8  byte received from the SPI byte engine; valid only when rx_valid=1.
REQ-007 Port: rx_valid  input  1  single-cycle strobe, one per received byte.
REQ-008 Port: tx_byte  output  8  registered byte that the SPI byte engine shifts out next.
REQ-009 Port: led_r, led_g, led_b  output  1 each  active-high LED drives, equal to LED_CTRL[0], [1] and [2].

Function
REQ-010 Frame format: byte 0 is the command byte; bit7=1 selects write and bit7=0 selects read; bits[6:0] give the start address; every later byte in the frame is one data byte.
REQ-011 FSM states: IDLE, CMD, WRITE, READ.
REQ-012 FSM transitions: IDLE->CMD when cs_n=0; CMD->WRITE or READ on rx_valid, chosen by rx_byte[7]; any state->IDLE whenever cs_n=1.
REQ-013 cs_n=1 has priority over rx_valid in the same cycle: the byte is dropped and no register is written.
REQ-014 On the command byte, the 7-bit address register is loaded with rx_byte[6:0].
REQ-015 In WRITE, on each rx_valid, rx_byte is committed to reg[addr] at that clock edge, and addr then increments.
REQ-016 In READ, on each rx_valid, addr increments and no register is written.
REQ-017 The address increments modulo 128, so 0x7F wraps to 0x00.
REQ-018 tx_byte is SYNC_BYTE while in IDLE or CMD.
REQ-019 In READ or WRITE, tx_byte equals reg[addr], registered, and updates exactly one clock after any change of addr or of register contents.
REQ-020 Register map, read-only: 0x00-0x04 hold "A","R","G","U","S"; 0x05 holds VERSION.
REQ-021 Register map, LED_CTRL at 0x06: read/write; bits[2:0] are stored; bits[7:3] read as 0.
REQ-022 Register map, SCRATCH at 0x07: read/write, 8 bits.
REQ-023 Register map, FRAME_CNT at 0x08: read-only, 8 bits.
REQ-024 Register map, STATUS at 0x09: bit0 is ERR_RO, sticky; writing 1 to bit0 clears it (write-1-to-clear); other bits read as 0.
REQ-025 Addresses 0x0A-0x7F read as 0x00; writes to them are ignored and do not set an error.
REQ-026 A write to any address 0x00-0x05 or 0x08 is discarded and sets ERR_RO on the same edge.
REQ-027 FRAME_CNT increments by 1, wrapping 0xFF->0x00, on the cs_n 0->1 transition, but only if the FSM was in READ or WRITE at that time.
REQ-028 A frame aborted in CMD (no command byte received) does not increment FRAME_CNT.
REQ-029 Bytes committed before cs_n deasserts stay committed.

Reset
REQ-030 While rst=1, all of the following hold: state=IDLE, addr=0, LED_CTRL=0, SCRATCH=0, FRAME_CNT=0, ERR_RO=0, tx_byte=SYNC_BYTE, led_r/g/b=0, and the cs_n edge register=1.
REQ-031 Reset asserted mid-frame aborts the frame immediately and does not increment FRAME_CNT.
REQ-032 After reset releases with cs_n=0, the FSM enters CMD and the next received byte is treated as a command byte.

Verification
REQ-033 ID read: send command 0x00 followed by 6 dummy bytes -> tx_byte sequence is 0xA5, "A", "R", "G", "U", "S", 0x01; FRAME_CNT=1 after cs_n rises.
REQ-034 LED burst write: send 0x86, 0x05, 0x3C -> LED_CTRL=0x05, led_r=1, led_g=0, led_b=1, SCRATCH=0x3C; a following read 0x06 returns 0x05 then 0x3C.
REQ-035 RO write and clear: send 0x81, 0xFF -> reg 0x01 still reads "R" and STATUS reads 0x01; then send 0x89, 0x01 -> STATUS reads 0x00.
REQ-036 Wrap and abort: read at 0x7F with 2 data bytes -> tx_byte shows 0x00 then "A"; a frame with cs_n low but no bytes leaves FRAME_CNT unchanged.
REQ-037 Collisions: rx_valid coincident with cs_n rising in WRITE -> no write occurs; 256 complete frames -> FRAME_CNT=0x00.
REQ-038 Reset mid-write: assert rst after 0x87, 0x11 -> SCRATCH=0x00, FRAME_CNT=0x00, tx_byte=0xA5.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
//
// Purpose:
//   Register-file front end for an SPI byte engine. Each frame starts when
//   cs_n goes low. Its first byte is a command: bit7 selects write (1) or
//   read (0), and bits[6:0] give the start address. Every later byte is a
//   data byte. The address auto-increments after each data byte and wraps
//   modulo 128. The block also drives the byte that the engine shifts out
//   next, and drives three LED outputs from the LED_CTRL register.
//
// Register map:
//   0x00-0x04  "ARGUS" ID string      (read-only)
//   0x05       VERSION                (read-only)
//   0x06       LED_CTRL[2:0]          (read/write, bits[7:3] read 0)
//   0x07       SCRATCH                (read/write)
//   0x08       FRAME_CNT              (read-only, completed data frames)
//   0x09       STATUS, bit0 = ERR_RO  (sticky, write-1-to-clear)
//   0x0A-0x7F  read as 0x00, writes ignored
//   A write to a read-only address is dropped and sets ERR_RO.
//
// Ports:
//   clk       in   1  system clock (100 MHz domain)
//   rst       in   1  asynchronous reset, active high
//   cs_n      in   1  SPI chip select, active low, already synchronous to clk
//   rx_byte   in   8  received byte, valid when rx_valid = 1
//   rx_valid  in   1  one-cycle strobe per received byte
//   tx_byte   out  8  registered byte to shift out next
//   led_r     out  1  LED_CTRL[0]
//   led_g     out  1  LED_CTRL[1]
//   led_b     out  1  LED_CTRL[2]
// ---------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter logic [7:0] VERSION   = 8'h01,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] tx_byte,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // Register addresses
    localparam logic [6:0] ADDR_ID0     = 7'h00;
    localparam logic [6:0] ADDR_ID1     = 7'h01;
    localparam logic [6:0] ADDR_ID2     = 7'h02;
    localparam logic [6:0] ADDR_ID3     = 7'h03;
    localparam logic [6:0] ADDR_ID4     = 7'h04;
    localparam logic [6:0] ADDR_VERSION = 7'h05;
    localparam logic [6:0] ADDR_LED     = 7'h06;
    localparam logic [6:0] ADDR_SCRATCH = 7'h07;
    localparam logic [6:0] ADDR_FCNT    = 7'h08;
    localparam logic [6:0] ADDR_STATUS  = 7'h09;

    // Storage and control state
    state_t     state_r;
    logic [6:0] addr_r;
    logic [2:0] led_ctrl_r;
    logic [7:0] scratch_r;
    logic [7:0] frame_cnt_r;
    logic       err_ro_r;
    logic       cs_n_q_r;
    logic [7:0] tx_byte_r;

    // Combinational decode
    logic       cs_rise_s;
    logic       in_data_s;
    logic       byte_ok_s;
    logic       wr_en_s;
    logic       wr_led_s;
    logic       wr_scratch_s;
    logic       err_set_s;
    logic       err_clr_s;
    logic [7:0] rd_data_s;

    // Read view of the register map. Unmapped addresses return zero.
    function automatic logic [7:0] reg_read(
        input logic [6:0] addr,
        input logic [2:0] led_ctrl,
        input logic [7:0] scratch,
        input logic [7:0] frame_cnt,
        input logic       err_ro
    );
        logic [7:0] data;
        case (addr)
            ADDR_ID0:     data = 8'h41;                  // "A"
            ADDR_ID1:     data = 8'h52;                  // "R"
            ADDR_ID2:     data = 8'h47;                  // "G"
            ADDR_ID3:     data = 8'h55;                  // "U"
            ADDR_ID4:     data = 8'h53;                  // "S"
            ADDR_VERSION: data = VERSION;
            ADDR_LED:     data = {5'b00000, led_ctrl};
            ADDR_SCRATCH: data = scratch;
            ADDR_FCNT:    data = frame_cnt;
            ADDR_STATUS:  data = {7'b0000000, err_ro};
            default:      data = 8'h00;
        endcase
        return data;
    endfunction

    // Read-only addresses, where a write is treated as an error.
    function automatic logic is_read_only(input logic [6:0] addr);
        logic ro;
        case (addr)
            ADDR_ID0, ADDR_ID1, ADDR_ID2, ADDR_ID3,
            ADDR_ID4, ADDR_VERSION, ADDR_FCNT: ro = 1'b1;
            default:                           ro = 1'b0;
        endcase
        return ro;
    endfunction

    // Frame qualifiers: a deasserted cs_n beats any byte strobe in the same cycle.
    always_comb begin
        cs_rise_s = 1'b0;
        in_data_s = 1'b0;
        byte_ok_s = 1'b0;
        wr_en_s   = 1'b0;
        if (cs_n && !cs_n_q_r) begin
            cs_rise_s = 1'b1;
        end else begin
            cs_rise_s = 1'b0;
        end
        if ((state_r == ST_WRITE) || (state_r == ST_READ)) begin
            in_data_s = 1'b1;
        end else begin
            in_data_s = 1'b0;
        end
        if (rx_valid && !cs_n) begin
            byte_ok_s = 1'b1;
        end else begin
            byte_ok_s = 1'b0;
        end
        if (byte_ok_s && (state_r == ST_WRITE)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Write-address decode into per-register strobes.
    always_comb begin
        wr_led_s     = 1'b0;
        wr_scratch_s = 1'b0;
        err_set_s    = 1'b0;
        err_clr_s    = 1'b0;
        if (wr_en_s) begin
            if (is_read_only(addr_r)) begin
                err_set_s = 1'b1;
            end else begin
                case (addr_r)
                    ADDR_LED:     wr_led_s     = 1'b1;
                    ADDR_SCRATCH: wr_scratch_s = 1'b1;
                    ADDR_STATUS:  err_clr_s    = rx_byte[0];
                    default:      err_set_s    = 1'b0;
                endcase
            end
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Read data for the current address.
    always_comb begin
        rd_data_s = reg_read(addr_r, led_ctrl_r, scratch_r, frame_cnt_r, err_ro_r);
    end

    // Frame FSM with its address pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= 7'h00;
        end else if (cs_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_CMD;
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        addr_r  <= rx_byte[6:0];
                        state_r <= rx_byte[7] ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE, ST_READ: begin
                    // 7-bit pointer wraps 0x7F -> 0x00 naturally.
                    if (rx_valid) begin
                        addr_r <= addr_r + 7'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Writable registers: LED_CTRL and SCRATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_ctrl_r <= 3'b000;
            scratch_r  <= 8'h00;
        end else begin
            if (wr_led_s) begin
                led_ctrl_r <= rx_byte[2:0];
            end
            if (wr_scratch_s) begin
                scratch_r <= rx_byte;
            end
        end
    end

    // Sticky read-only-violation flag. A new violation outranks a clear,
    // although both cannot target the same address in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ro_r <= 1'b0;
        end else if (err_set_s) begin
            err_ro_r <= 1'b1;
        end else if (err_clr_s) begin
            err_ro_r <= 1'b0;
        end
    end

    // Chip-select history, used to find the end of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_q_r <= 1'b1;
        end else begin
            cs_n_q_r <= cs_n;
        end
    end

    // Count frames that got past the command byte. Aborted frames do not count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= 8'h00;
        end else if (cs_rise_s && in_data_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end
    end

    // Outgoing byte: the sync pattern outside data phases, otherwise the
    // addressed register one clock after any change. Gating on cs_n makes
    // the sync pattern return on the same edge that the FSM goes idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_byte_r <= SYNC_BYTE;
        end else if (!cs_n && in_data_s) begin
            tx_byte_r <= rd_data_s;
        end else begin
            tx_byte_r <= SYNC_BYTE;
        end
    end

    assign tx_byte = tx_byte_r;
    assign led_r   = led_ctrl_r[0];
    assign led_g   = led_ctrl_r[1];
    assign led_b   = led_ctrl_r[2];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_ctrl
//
// Directed frames plus randomized frames, checked against a transaction-level
// model of the register map. Before each byte is sent, the bench predicts the
// byte that will be shifted out and the LED outputs.
// ---------------------------------------------------------------------------
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst;
    logic       cs_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       led_r;
    logic       led_g;
    logic       led_b;

    int vectors;
    int miscompares;

    // Reference model state
    logic [2:0] m_led;
    logic [7:0] m_scr;
    logic [7:0] m_cnt;
    logic       m_err;
    logic [6:0] m_addr;
    int         m_phase;   // 0 = awaiting command, 1 = write frame, 2 = read frame

    spi_reg_ctrl #(.VERSION(8'h01), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .led_r    (led_r),
        .led_g    (led_g),
        .led_b    (led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] m_read(input logic [6:0] a);
        logic [7:0] id [0:4];
        id[0] = 8'h41; id[1] = 8'h52; id[2] = 8'h47; id[3] = 8'h55; id[4] = 8'h53;
        if (a <= 7'd4)       return id[a];
        else if (a == 7'd5)  return 8'h01;
        else if (a == 7'd6)  return {5'd0, m_led};
        else if (a == 7'd7)  return m_scr;
        else if (a == 7'd8)  return m_cnt;
        else if (a == 7'd9)  return {7'd0, m_err};
        else                 return 8'h00;
    endfunction

    task automatic m_write(input logic [6:0] a, input logic [7:0] d);
        if (a <= 7'd5 || a == 7'd8) m_err = 1'b1;
        else if (a == 7'd6)         m_led = d[2:0];
        else if (a == 7'd7)         m_scr = d;
        else if (a == 7'd9 && d[0]) m_err = 1'b0;
    endtask

    task automatic m_reset();
        m_led = 3'd0; m_scr = 8'h00; m_cnt = 8'h00; m_err = 1'b0;
        m_addr = 7'd0; m_phase = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    task automatic chk_leds(input string tag);
        chk(tag, {5'd0, led_b, led_g, led_r}, {5'd0, m_led});
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        m_phase = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs_n = 1'b1;
        if (m_phase != 0) m_cnt = m_cnt + 8'd1;
        m_phase = 0;
        repeat (2) @(negedge clk);
        chk("tx_idle", tx_byte, 8'hA5);
        chk_leds("led_idle");
    endtask

    // Check the predicted outgoing byte, send one byte, then update the model.
    task automatic send_byte(input logic [7:0] b);
        chk("tx", tx_byte, (m_phase == 0) ? 8'hA5 : m_read(m_addr));
        chk_leds("led");
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        if (m_phase == 0) begin
            m_addr  = b[6:0];
            m_phase = b[7] ? 1 : 2;
        end else begin
            if (m_phase == 1) m_write(m_addr, b);
            m_addr = m_addr + 7'd1;
        end
    endtask

    // End a frame with a byte strobe in the same cycle as cs_n rising.
    task automatic collide_end(input logic [7:0] b);
        @(negedge clk);
        cs_n     = 1'b1;
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (m_phase != 0) m_cnt = m_cnt + 8'd1;
        m_phase = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic read_frame(input logic [6:0] a, input int n);
        cs_low();
        send_byte({1'b0, a});
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
        cs_high();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; cs_n = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_byte, 8'hA5);
        chk_leds("rst_led");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_tx", tx_byte, 8'hA5);

        // ID string read, then FRAME_CNT read
        read_frame(7'h00, 6);
        read_frame(7'h08, 1);

        // LED and SCRATCH burst write, then read back
        cs_low();
        send_byte(8'h86); send_byte(8'h05); send_byte(8'h3C);
        cs_high();
        read_frame(7'h06, 2);

        // Write to a read-only register sets ERR_RO; write-1-to-clear
        cs_low(); send_byte(8'h81); send_byte(8'hFF); cs_high();
        read_frame(7'h01, 1);
        read_frame(7'h09, 1);
        cs_low(); send_byte(8'h89); send_byte(8'h01); cs_high();
        read_frame(7'h09, 1);

        // Address wrap, then a frame aborted before its command byte
        read_frame(7'h7F, 2);
        cs_low(); cs_high();
        read_frame(7'h08, 1);

        // Byte coincident with cs_n rising is dropped
        cs_low(); send_byte(8'h87); collide_end(8'h99);
        read_frame(7'h07, 3);

        // 256 complete frames: FRAME_CNT wraps back to its current value
        for (int i = 0; i < 256; i++) begin
            cs_low(); send_byte(8'h08); cs_high();
        end
        read_frame(7'h08, 1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            logic [6:0] a;
            int         len;
            if ($urandom_range(0, 3) == 0) a = 7'h7E + 7'($urandom_range(0, 1));
            else                           a = 7'($urandom_range(0, 11));
            len = $urandom_range(0, 5);
            cs_low();
            send_byte({1'($urandom_range(0, 1)), a});
            for (int i = 0; i < len; i++) send_byte(8'($urandom));
            cs_high();
        end
        read_frame(7'h06, 4);

        // Reset in the middle of a write frame
        cs_low(); send_byte(8'h87); send_byte(8'h11);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        m_reset();
        chk("midrst_tx", tx_byte, 8'hA5);
        chk_leds("midrst_led");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
        cs_high();
        read_frame(7'h08, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
